// File: rtl/full_adder_response_checker.sv
// Response checker for a 1-bit full adder: compares sampled DUT outputs against the
// golden sum/carry, counts vectors and mismatches, and finishes once all 8 input combinations are covered.
module full_adder_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             s,
  input  logic             cy,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [7:0]       cov_q, cov_d;
  logic             fev_q, fev_d;
  logic [2:0]       fe_q, fe_d;

  logic [2:0] abc;
  logic       exp_s, exp_cy, mismatch;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign abc      = {a, b, c};
  assign exp_s    = a ^ b ^ c;
  assign exp_cy   = (a & b) | (a & c) | (b & c);
  assign mismatch = (s != exp_s) | (cy != exp_cy);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    fev_d   = fev_q;
    fe_d    = fe_q;
    case (state_q)
      IDLE, DONE: begin
        // A start pulse opens a fresh run; the vector on that edge is discarded.
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          err_d   = '0;
          cov_d   = '0;
          fev_d   = 1'b0;
          fe_d    = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          vec_d = sat_inc(vec_q);
          cov_d = cov_q | (8'd1 << abc);
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (!fev_q) begin
              fev_d = 1'b1;
              fe_d  = abc;
            end
          end
          if (cov_d == 8'hFF) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      fev_q   <= 1'b0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      fev_q   <= fev_d;
      fe_q    <= fe_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_count       = vec_q;
  assign err_count       = err_q;
  assign coverage        = cov_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fe_q;

endmodule

// File: tb/tb_full_adder_response_checker.sv
// Bench for full_adder_response_checker: directed table, hand sequences and random traffic
// against a behavioural model, with an 8-bit and a 4-bit counter instance side by side.
module tb_full_adder_response_checker;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, a, b, c, s, cy;

  logic       busy8, done8, pass8, fev8;
  logic [7:0] vc8, ec8, cov8;
  logic [2:0] fe8;
  logic       busy4, done4, pass4, fev4;
  logic [3:0] vc4, ec4;
  logic [7:0] cov4;
  logic [2:0] fe4;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model, index 0 = 8-bit counters, 1 = 4-bit counters.
  int  mst[2];   // 0 idle, 1 run, 2 done
  int  mvec[2], merr[2], mfe[2];
  bit  mfev[2];
  bit  seen[2][8];
  int  mmax[2] = '{255, 15};

  full_adder_response_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .s(s), .cy(cy),
    .busy(busy8), .done(done8), .pass(pass8), .vec_count(vc8), .err_count(ec8),
    .coverage(cov8), .first_err_valid(fev8), .first_err_vec(fe8));

  full_adder_response_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .s(s), .cy(cy),
    .busy(busy4), .done(done4), .pass(pass4), .vec_count(vc4), .err_count(ec4),
    .coverage(cov4), .first_err_valid(fev4), .first_err_vec(fe4));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mst[k] = 0; mvec[k] = 0; merr[k] = 0; mfe[k] = 0; mfev[k] = 0;
      for (int j = 0; j < 8; j++) seen[k][j] = 0;
    end
  endtask

  task automatic model_edge(input bit st, input bit vl, input int abc, input bit sv, input bit cv);
    int  ones;
    bit  bad;
    bit  all;
    ones = abc[2] + abc[1] + abc[0];
    bad  = (sv != (ones % 2)) || (cv != (ones >= 2));
    for (int k = 0; k < 2; k++) begin
      if (mst[k] != 1) begin
        if (st) begin
          mst[k] = 1; mvec[k] = 0; merr[k] = 0; mfe[k] = 0; mfev[k] = 0;
          for (int j = 0; j < 8; j++) seen[k][j] = 0;
        end
      end else if (vl) begin
        if (mvec[k] < mmax[k]) mvec[k]++;
        if (bad) begin
          if (merr[k] < mmax[k]) merr[k]++;
          if (!mfev[k]) begin mfev[k] = 1; mfe[k] = abc; end
        end
        seen[k][abc] = 1;
        all = 1;
        for (int j = 0; j < 8; j++) if (!seen[k][j]) all = 0;
        if (all) mst[k] = 2;
      end
    end
  endtask

  function automatic logic [7:0] mcov(input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = seen[k][j];
    return v;
  endfunction

  task automatic check_model();
    cmp("busy8", busy8, mst[0] == 1);
    cmp("done8", done8, mst[0] == 2);
    cmp("pass8", pass8, (mst[0] == 2) && (merr[0] == 0));
    cmp("vec8",  vc8,   mvec[0]);
    cmp("err8",  ec8,   merr[0]);
    cmp("cov8",  cov8,  mcov(0));
    cmp("fev8",  fev8,  mfev[0]);
    cmp("fe8",   fe8,   mfe[0]);
    cmp("busy4", busy4, mst[1] == 1);
    cmp("done4", done4, mst[1] == 2);
    cmp("pass4", pass4, (mst[1] == 2) && (merr[1] == 0));
    cmp("vec4",  vc4,   mvec[1]);
    cmp("err4",  ec4,   merr[1]);
    cmp("cov4",  cov4,  mcov(1));
    cmp("fev4",  fev4,  mfev[1]);
    cmp("fe4",   fe4,   mfe[1]);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check #1 later.
  task automatic cyc(input bit st, input bit vl, input int abc, input bit fs, input bit fc);
    int ones;
    ones     = abc[2] + abc[1] + abc[0];
    start    = st;
    in_valid = vl;
    {a, b, c} = abc[2:0];
    s        = (ones % 2) ^ fs;
    cy       = (ones >= 2) ^ fc;
    @(posedge clk);
    model_edge(st, vl, abc, s, cy);
    #1;
    check_model();
  endtask

  typedef struct {
    bit st; bit vl; int abc; bit fs; bit fc;
    int e_vec; int e_err; bit e_busy; bit e_done; bit e_pass;
    logic [7:0] e_cov; bit e_fev; int e_fe;
  } row_t;

  row_t tbl[18];

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; a = 0; b = 0; c = 0; s = 0; cy = 0;
    model_reset();
    #12;
    cmp("rst_busy", busy8, 0);
    cmp("rst_vec",  vc8,   0);
    cmp("rst_cov",  cov8,  0);
    cmp("rst_done", done8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 1 all correct, then run 2 (restart from DONE) with s bad on 101, cy bad on 111.
    for (int r = 0; r < 2; r++) begin
      tbl[r*9] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0};
      for (int k = 0; k < 8; k++) begin
        int e;
        e = (r == 0) ? 0 : (k < 5 ? 0 : (k < 7 ? 1 : 2));
        tbl[r*9+1+k] = '{0, 1, k, (r == 1 && k == 5), (r == 1 && k == 7),
                         k + 1, e, (k < 7), (k == 7), (k == 7 && e == 0),
                         8'((2 << k) - 1), (e > 0), (e > 0) ? 5 : 0};
      end
    end
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].st, tbl[i].vl, tbl[i].abc, tbl[i].fs, tbl[i].fc);
      cmp("t_vec",  vc8,   tbl[i].e_vec);
      cmp("t_err",  ec8,   tbl[i].e_err);
      cmp("t_busy", busy8, tbl[i].e_busy);
      cmp("t_done", done8, tbl[i].e_done);
      cmp("t_pass", pass8, tbl[i].e_pass);
      cmp("t_cov",  cov8,  tbl[i].e_cov);
      cmp("t_fev",  fev8,  tbl[i].e_fev);
      cmp("t_fe",   fe8,   tbl[i].e_fe);
    end

    // DONE holds: in_valid ignored, start ignored mid-run later.
    cyc(0, 1, 3, 1, 0);
    cmp("hold_err", ec8, 2);

    // Gapped run over 000..110 only, then 111 completes it.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, i % 7, 0, 0);
      cyc((i == 4), 0, 7, 0, 0);
    end
    cmp("gap_cov",  cov8,  8'h7F);
    cmp("gap_vec",  vc8,   20);
    cmp("gap_busy", busy8, 1);
    cmp("gap_done", done8, 0);
    cyc(0, 1, 7, 0, 0);
    cmp("gap_done2", done8, 1);
    cmp("gap_vec2",  vc8,   21);

    // Saturation: 20 bad 000 vectors, then the remaining 7 correct.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1, 0);
    cmp("sat_vec4", vc4, 15);
    cmp("sat_err4", ec4, 15);
    cmp("sat_err8", ec8, 20);
    for (int k = 1; k < 8; k++) cyc(0, 1, k, 0, 0);
    cmp("sat_done4", done4, 1);
    cmp("sat_err4b", ec4, 15);
    cmp("sat_pass4", pass4, 0);

    // Asynchronous reset mid-run.
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, k, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("ar_busy", busy8, 0);
    cmp("ar_vec",  vc8,   0);
    cmp("ar_cov",  cov8,  0);
    cmp("ar_fe",   fe8,   0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 5, 1, 1);
    cmp("ar_idle_busy", busy8, 0);
    cmp("ar_idle_vec",  vc8,   0);

    // Start with in_valid high in IDLE: that vector is not counted.
    cyc(1, 1, 3, 1, 1);
    cmp("st_vec", vc8, 0);
    cmp("st_err", ec8, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, k, 0, 0);
    cmp("st_pass", pass8, 1);
    cyc(1, 1, 2, 1, 0);
    cmp("re_vec",  vc8,  0);
    cmp("re_done", done8, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 25) == 0, $urandom % 2, $urandom % 8,
          ($urandom % 6) == 0, ($urandom % 6) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/full_adder_response_checker.md
Name: full_adder_response_checker

Overview:
- Hardware checker for the 1-bit full adder. It is the receiving end of the full-adder stimulus stream.
- Samples operand inputs (a, b, c) and DUT outputs (s, cy) each valid cycle, computes the golden sum/carry and counts vectors and mismatches.
- Tracks coverage of the 8 input combinations and declares pass/fail once all 8 have been seen.
- Sits beside any full-adder instance for on-chip self-check or bench-side scoreboarding.

Parameters:
- CNT_W, 8, width of vec_count and err_count; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a check run.
- in_valid  input  1  a/b/c/s/cy are valid this cycle.
- a  input  1  operand a applied to DUT.
- b  input  1  operand b applied to DUT.
- c  input  1  carry-in applied to DUT.
- s  input  1  DUT sum output.
- cy  input  1  DUT carry output.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  done && err_count==0.
- vec_count  output  CNT_W  valid vectors accepted this run.
- err_count  output  CNT_W  mismatching vectors this run.
- coverage  output  8  bit {a,b,c} set once that combination has been seen.
- first_err_valid  output  1  at least one mismatch captured.
- first_err_vec  output  3  {a,b,c} of the first mismatch.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and all outputs/registers to 0. Releasing reset is synchronous to clk.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the edge where the coverage update makes coverage == 8'hFF.
  - DONE -> RUN on start.
  - In RUN, start is ignored.
- Entering RUN clears vec_count, err_count, coverage, first_err_valid and first_err_vec on the same edge.
  - in_valid on the start edge is ignored; that vector is not counted.
- Golden model:
  - exp_s = a^b^c.
  - exp_cy = (a&b)|(a&c)|(b&c).
  - Mismatch = (s!=exp_s) | (cy!=exp_cy).
- Per RUN edge with in_valid=1:
  - vec_count +1, saturating.
  - On mismatch, err_count +1, saturating.
  - coverage[{a,b,c}] set.
  - On the first mismatch only (first_err_valid=0), first_err_vec <= {a,b,c} and first_err_valid <= 1.
- Latency: all outputs are registered. An effect is visible the cycle after the sampling edge. done/pass rise the cycle after the edge sampling the final uncovered combination. That final vector is counted/checked normally.
- in_valid low: no update. Gaps of any length are allowed.
- Repeated combinations count in vec_count/err_count but do not advance coverage. The run stays in RUN until all 8 are covered; there is no timeout.
- DONE: in_valid is ignored and all results hold until start or reset.
- Saturation: counters stick at all-ones and never wrap.
- Reset mid-RUN: immediate return to IDLE with all results cleared.

Test Plan:
- Reset, start, then 8 consecutive valid vectors 000..111 with correct s/cy -> done=1 the cycle after the 8th, vec_count=8, err_count=0, coverage=8'hFF, pass=1, first_err_valid=0.
- Same sequence with s inverted on vector {a,b,c}=101 and cy inverted on 111 -> err_count=2, first_err_vec=3'b101, first_err_valid=1, done=1, pass=0.
- Start, then 20 valid correct vectors cycling through 000..110 only, with in_valid deasserted every other cycle -> busy=1, done=0, coverage=8'h7F, vec_count=20. Then one valid 111 -> done=1, vec_count=21.
- CNT_W=4: start, 20 valid vectors of 000 with s=1 -> err_count and vec_count saturate at 15. Then the remaining 7 combinations correct -> done=1, err_count=15, pass=0.
- rst_n pulsed low mid-run after 3 vectors (asynchronous, between edges) -> all outputs 0 immediately. A further in_valid without start -> no change, busy=0.
- Start asserted with in_valid=1 in IDLE, then start again from DONE -> the first vector is not counted. The restart clears all results and the next run behaves as in the first scenario.
